// File: rtl/sram2_responder_if.sv
// Request/response bundle between an AES core (master) and the block SRAM responder (slave).
// Handshake: r_en/w_en are always accepted at the edge they are sampled; each accepted
// request yields exactly one r_valid/w_ack pulse in the following cycle, there is no back-pressure.
interface sram2_responder_if;
  logic       r_en;
  logic [7:0] r_addr;
  logic       w_en;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_valid;
  logic       w_ack;
  logic       rd_blk_done;
  logic       wr_blk_done;
  logic       seq_err;
  logic       dbg_rd_active;
  logic       dbg_wr_active;

  modport master (
    output r_en, r_addr, w_en, w_addr, w_data,
    input  r_data, r_valid, w_ack, rd_blk_done, wr_blk_done, seq_err,
    input  dbg_rd_active, dbg_wr_active
  );

  modport slave (
    input  r_en, r_addr, w_en, w_addr, w_data,
    output r_data, r_valid, w_ack, rd_blk_done, wr_blk_done, seq_err,
    output dbg_rd_active, dbg_wr_active
  );
endinterface

// File: rtl/sram2_responder.sv
// 256x8 byte store with 1-cycle reads, write-first bypass, and per-path AES block
// tracking (beat counting, block-done pulses, sticky sequential-address error).
module sram2_blk_tracker #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en_i,
  input  logic [7:0] addr_i,
  output logic       done_o,
  output logic       seq_err_o,
  output logic       active_o
);
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_next;
  logic [7:0]      exp_q, exp_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
    end
  end

  // In IDLE the count is zero, so the first beat of a block naturally yields count 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    done_d    = 1'b0;
    seq_err_o = 1'b0;
    cnt_next  = cnt_q + CW'(1);
    if (en_i) begin
      if (state_q == ACTIVE && addr_i != exp_q) seq_err_o = 1'b1;
      exp_d = (state_q == IDLE) ? addr_i + 8'd1 : exp_q + 8'd1;
      if (cnt_next == LAST) begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ACTIVE;
        cnt_d   = cnt_next;
      end
    end
  end

  assign done_o   = done_q;
  assign active_o = (state_q == ACTIVE);
endmodule

module sram2_responder #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  sram2_responder_if.slave    bus
);
  logic [7:0] mem_q [256];
  logic [7:0] r_data_q;
  logic       r_valid_q;
  logic       w_ack_q;
  logic       seq_err_q;
  logic       rd_seq_err, wr_seq_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else if (bus.w_en) begin
      mem_q[bus.w_addr] <= bus.w_data;
    end
  end

  // Same-edge write to the read address returns the new byte (write-first).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      w_ack_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      r_valid_q <= bus.r_en;
      w_ack_q   <= bus.w_en;
      seq_err_q <= seq_err_q | rd_seq_err | wr_seq_err;
      if (bus.r_en) begin
        r_data_q <= (bus.w_en && bus.w_addr == bus.r_addr) ? bus.w_data : mem_q[bus.r_addr];
      end
    end
  end

  sram2_blk_tracker #(.BLOCK_BYTES(BLOCK_BYTES)) u_rd_trk (
    .clk       (clk),
    .n_rst     (n_rst),
    .en_i      (bus.r_en),
    .addr_i    (bus.r_addr),
    .done_o    (bus.rd_blk_done),
    .seq_err_o (rd_seq_err),
    .active_o  (bus.dbg_rd_active)
  );

  sram2_blk_tracker #(.BLOCK_BYTES(BLOCK_BYTES)) u_wr_trk (
    .clk       (clk),
    .n_rst     (n_rst),
    .en_i      (bus.w_en),
    .addr_i    (bus.w_addr),
    .done_o    (bus.wr_blk_done),
    .seq_err_o (wr_seq_err),
    .active_o  (bus.dbg_wr_active)
  );

  assign bus.r_data  = r_data_q;
  assign bus.r_valid = r_valid_q;
  assign bus.w_ack   = w_ack_q;
  assign bus.seq_err = seq_err_q;
endmodule

// File: tb/tb_sram2_responder.sv
// Scoreboard bench for sram2_responder: a byte-memory/block model predicts each
// response when the request is driven; a negedge monitor pops and compares.
module tb_sram2_responder;
  localparam int BB = 16;

  logic clk;
  logic n_rst;
  sram2_responder_if bus ();

  sram2_responder #(.BLOCK_BYTES(BB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model state
  logic [7:0] mdl_mem [256];
  int         m_rd_cnt, m_wr_cnt;
  logic [7:0] m_rd_exp, m_wr_exp;
  logic       m_seq;
  logic [7:0] last_rd;

  // scoreboard: {seq_err, rd_blk_done, r_data} and {seq_err, wr_blk_done}
  logic [9:0] rd_exp_q [$];
  logic [1:0] wr_exp_q [$];

  always @(negedge clk) begin
    logic [9:0] re;
    logic [1:0] we;
    if (n_rst) begin
      if (bus.r_valid || rd_exp_q.size() != 0) begin
        check("r_valid", 32'(bus.r_valid), 32'(rd_exp_q.size() != 0));
        if (rd_exp_q.size() != 0) begin
          re = rd_exp_q.pop_front();
          check("r_data", 32'(bus.r_data), 32'(re[7:0]));
          check("rd_blk_done", 32'(bus.rd_blk_done), 32'(re[8]));
          check("seq_err_rd", 32'(bus.seq_err), 32'(re[9]));
          last_rd = re[7:0];
        end
      end else begin
        if (bus.rd_blk_done) check("rd_blk_done_stray", 32'(bus.rd_blk_done), 32'd0);
        if (bus.r_data !== last_rd) check("r_data_hold", 32'(bus.r_data), 32'(last_rd));
      end
      if (bus.w_ack || wr_exp_q.size() != 0) begin
        check("w_ack", 32'(bus.w_ack), 32'(wr_exp_q.size() != 0));
        if (wr_exp_q.size() != 0) begin
          we = wr_exp_q.pop_front();
          check("wr_blk_done", 32'(bus.wr_blk_done), 32'(we[0]));
          check("seq_err_wr", 32'(bus.seq_err), 32'(we[1]));
        end
      end else if (bus.wr_blk_done) begin
        check("wr_blk_done_stray", 32'(bus.wr_blk_done), 32'd0);
      end
    end
  end

  // driver tasks: called just after a rising edge, request is sampled at the next one
  task automatic beat(input logic ren, input logic [7:0] ra,
                      input logic wen, input logic [7:0] wa, input logic [7:0] wd);
    logic rd_done, wr_done;
    logic [7:0] rdat;
    rd_done = 1'b0;
    wr_done = 1'b0;
    bus.r_en = ren; bus.r_addr = ra;
    bus.w_en = wen; bus.w_addr = wa; bus.w_data = wd;
    if (wen) begin
      mdl_mem[wa] = wd;
      if (m_wr_cnt != 0 && wa != m_wr_exp) m_seq = 1'b1;
      m_wr_exp = ((m_wr_cnt == 0) ? wa : m_wr_exp) + 8'd1;
      m_wr_cnt++;
      if (m_wr_cnt == BB) begin wr_done = 1'b1; m_wr_cnt = 0; end
    end
    if (ren) begin
      if (m_rd_cnt != 0 && ra != m_rd_exp) m_seq = 1'b1;
      m_rd_exp = ((m_rd_cnt == 0) ? ra : m_rd_exp) + 8'd1;
      m_rd_cnt++;
      if (m_rd_cnt == BB) begin rd_done = 1'b1; m_rd_cnt = 0; end
    end
    rdat = mdl_mem[ra];
    @(posedge clk);
    #1;
    if (ren) rd_exp_q.push_back({m_seq, rd_done, rdat});
    if (wen) wr_exp_q.push_back({m_seq, wr_done});
    bus.r_en = 1'b0;
    bus.w_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    idle(1);
    n_rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    m_rd_cnt = 0; m_wr_cnt = 0; m_rd_exp = 8'h00; m_wr_exp = 8'h00;
    m_seq = 1'b0; last_rd = 8'h00;
    rd_exp_q.delete();
    wr_exp_q.delete();
    @(negedge clk);
    check("rst_r_data", 32'(bus.r_data), 32'd0);
    check("rst_r_valid", 32'(bus.r_valid), 32'd0);
    check("rst_w_ack", 32'(bus.w_ack), 32'd0);
    check("rst_rd_blk_done", 32'(bus.rd_blk_done), 32'd0);
    check("rst_wr_blk_done", 32'(bus.wr_blk_done), 32'd0);
    check("rst_seq_err", 32'(bus.seq_err), 32'd0);
    check("rst_rd_fsm", 32'(bus.dbg_rd_active), 32'd0);
    check("rst_wr_fsm", 32'(bus.dbg_wr_active), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.r_en = 1'b0; bus.r_addr = 8'h00;
    bus.w_en = 1'b0; bus.w_addr = 8'h00; bus.w_data = 8'h00;
    idle(2);
    do_reset();

    // 16-byte write block then read it back
    for (int i = 0; i < 16; i++) beat(1'b0, 8'h00, 1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) beat(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 8'h00);
    idle(2);

    // same-edge bypass, then independent different-address access
    beat(1'b1, 8'h05, 1'b1, 8'h05, 8'h3C);
    beat(1'b1, 8'h1F, 1'b1, 8'h06, 8'h77);
    idle(2);

    // wrapping read block, then an address jump that must latch seq_err
    do_reset();
    for (int i = 0; i < 11; i++) beat(1'b1, 8'hF8 + 8'(i), 1'b0, 8'h00, 8'h00);
    beat(1'b1, 8'h09, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h0A + 8'(i), 1'b0, 8'h00, 8'h00);
    idle(2);
    check("seq_err_sticky", 32'(bus.seq_err), 32'd1);

    // partial block discarded by reset, then a full block from 0x40 reading zeros
    do_reset();
    for (int i = 0; i < 7; i++) beat(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 8'h00);
    do_reset();
    for (int i = 0; i < 16; i++) beat(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00, 8'h00);
    idle(2);

    // random data block, read back with 3-cycle gaps between beats
    for (int i = 0; i < 16; i++)
      beat(1'b0, 8'h00, 1'b1, 8'h60 + 8'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 8'h60 + 8'(i), 1'b0, 8'h00, 8'h00);
      idle(3);
    end
    check("rd_fsm_idle_end", 32'(bus.dbg_rd_active), 32'd0);
    check("wr_fsm_idle_end", 32'(bus.dbg_wr_active), 32'd0);
    check("seq_err_clean", 32'(bus.seq_err), 32'd0);
    idle(2);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram2_responder.md
SRAM2_RESPONDER -- requirements
Module: sram2_responder

Interface
REQ-001 Parameter BLOCK_BYTES, default 16, number of byte accesses that form one AES block transfer.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 r_en  input  1  read request, sampled each rising edge.
REQ-005 r_addr  input  8  read byte address.
REQ-006 w_en  input  1  write request, sampled each rising edge.
REQ-007 w_addr  input  8  write byte address.
REQ-008 w_data  input  8  write byte.
REQ-009 r_data  output  8  read byte, valid when r_valid high.
REQ-010 r_valid  output  1  one-cycle pulse per accepted read.
REQ-011 w_ack  output  1  one-cycle pulse per accepted write.
REQ-012 rd_blk_done  output  1  one-cycle pulse on completion of BLOCK_BYTES reads.
REQ-013 wr_blk_done  output  1  one-cycle pulse on completion of BLOCK_BYTES writes.
REQ-014 seq_err  output  1  sticky flag, non-consecutive address inside a block.

Function
REQ-015 Storage: 256 x 8 array, indexed directly by 8-bit address.
REQ-016 Write: w_en high at edge k -> mem[w_addr] <= w_data at edge k; w_ack high during cycle k+1 only.
REQ-017 Read latency 1: r_en high at edge k -> r_data = mem[r_addr] and r_valid high during cycle k+1.
REQ-018 r_data holds its last value while r_valid is low.
REQ-019 Same-edge r_en and w_en, r_addr == w_addr -> r_data returns the new w_data (write-first bypass).
REQ-020 Same-edge r_en and w_en, different addresses -> both serviced independently, no stall.
REQ-021 Read and write paths each have an independent FSM: IDLE, ACTIVE.
REQ-022 IDLE -> ACTIVE on first enable; base address latched as expected = addr + 1; beat count = 1.
REQ-023 ACTIVE with enable: beat count += 1; expected += 1 (8-bit, 8'hFF wraps to 8'h00).
REQ-024 ACTIVE with enable and addr != expected -> seq_err set; access still performed.
REQ-025 Beat count reaching BLOCK_BYTES -> blk_done pulse coincident with that beat's r_valid/w_ack; FSM -> IDLE; count = 0.
REQ-026 ACTIVE with enable low -> state and count held (gaps allowed inside a block).
REQ-027 BLOCK_BYTES == 1 -> every access produces a blk_done pulse and stays in IDLE.
REQ-028 seq_err clears only on reset.
REQ-029 Beat counter width: ceil(log2(BLOCK_BYTES+1)) bits; no overflow past BLOCK_BYTES.

Reset
REQ-030 n_rst low: r_data=0, r_valid=0, w_ack=0, rd_blk_done=0, wr_blk_done=0, seq_err=0, both FSMs IDLE, counts 0, all memory bytes 0.
REQ-031 Reset mid-block discards the partial block; first access after release starts a new block.
REQ-032 Enables sampled in the same cycle that reset deasserts are accepted normally at the next edge.

Verification
REQ-033 Write 16 bytes addr 0x10..0x1F, data 0xA0..0xAF -> 16 w_ack pulses, wr_blk_done on 16th, seq_err=0.
REQ-034 Read 0x10..0x1F after REQ-033 -> r_data 0xA0..0xAF one cycle after each r_en; rd_blk_done with 16th r_valid.
REQ-035 Same edge r_en/w_en, addr 0x05, w_data 0x3C -> next cycle r_data=0x3C, r_valid=1, w_ack=1.
REQ-036 Read block starting 0xF8 -> addresses wrap 0xFF->0x00..0x07 with seq_err=0; jump 0x02->0x09 -> seq_err=1 and stays 1.
REQ-037 Reset after 7 reads, then 16 reads from 0x40 -> rd_blk_done only on the 16th post-reset read; all reads return 0x00.
REQ-038 Reads with idle gaps of 3 cycles between beats -> rd_blk_done still on 16th beat; no spurious r_valid in gaps.
